// File: rtl/vm1_bus_pkg.sv
// rtl/vm1_bus_pkg.sv - shared constants, state and target enums for the VM1 bus responder
package vm1_bus_pkg;

    localparam logic [15:0] TPS_ADDR       = 16'o177564;
    localparam logic [15:0] TPB_ADDR       = 16'o177566;
    localparam logic [15:0] DEFAULT_VECTOR = 16'o000064;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_HOLD
    } bus_state_e;

    typedef enum logic [1:0] {
        TGT_RAM,
        TGT_TPS,
        TGT_TPB,
        TGT_VEC
    } bus_target_e;

    // Byte reads return the addressed lane right-justified with a zero upper byte.
    function automatic logic [15:0] byte_lane(input logic [15:0] word, input logic hi);
        return hi ? {8'h00, word[15:8]} : {8'h00, word[7:0]};
    endfunction

endpackage

// File: rtl/vm1_bus_responder_if.sv
// rtl/vm1_bus_responder_if.sv - VM1 asynchronous bus signal bundle with CPU and responder views
interface vm1_bus_responder_if;

    logic [15:0] addr_i;
    logic [15:0] data_i;
    logic [15:0] data_o;
    logic        SYNC;
    logic        DIN;
    logic        DOUT;
    logic        WTBT;
    logic        IAKO;
    logic        RPLY;
    logic        VIRQ;

    modport master (
        output addr_i, data_i, SYNC, DIN, DOUT, WTBT, IAKO,
        input  data_o, RPLY, VIRQ
    );

    modport slave (
        input  addr_i, data_i, SYNC, DIN, DOUT, WTBT, IAKO,
        output data_o, RPLY, VIRQ
    );

endinterface

// File: rtl/vm1_bus_ram.sv
// rtl/vm1_bus_ram.sv - single-port word RAM with byte-lane write enables and registered read
module vm1_bus_ram #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    input  logic [1:0]    we,
    output logic [15:0]   rdata
);

    logic [15:0] mem [0:(1 << AW) - 1];

    always_ff @(posedge clk) begin
        if (we[0]) mem[addr][7:0]  <= wdata[7:0];
        if (we[1]) mem[addr][15:8] <= wdata[15:8];
        rdata <= mem[addr];
    end

endmodule

// File: rtl/vm1_bus_responder.sv
// rtl/vm1_bus_responder.sv - VM1 bus slave: RAM, console TPS/TPB registers and interrupt vector
module vm1_bus_responder
    import vm1_bus_pkg::*;
#(
    parameter int          RAM_AW      = 14,
    parameter int          WAIT_STATES = 0,
    parameter logic [15:0] VECTOR      = DEFAULT_VECTOR
) (
    input  logic                       clk,
    input  logic                       reset_n,
    vm1_bus_responder_if.slave         bus,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready
);

    localparam logic [16:0] RAM_LIMIT = 17'(1) << (RAM_AW + 1);
    localparam logic [2:0]  WAIT_LAST = 3'(WAIT_STATES);

    bus_state_e  state_q, state_n;
    bus_target_e tgt_q, tgt_hit;
    logic        hit, iak_req, start, ack, ack_wr;
    logic [RAM_AW:0] addr_q;
    logic        write_q, wtbt_q;
    logic [2:0]  wcnt_q;
    logic [15:0] data_q, rd_value;
    logic        rply_q;
    logic        ready_q, ie_q, irq_q, tx_valid_q;
    logic [7:0]  tx_data_q;
    logic        ready_n, ie_n, irq_n, tx_valid_n;
    logic [7:0]  tx_data_n;
    logic [15:0] ram_rdata, ram_wdata;
    logic [1:0]  ram_we;

    assign iak_req = bus.IAKO && bus.DIN;

    // Interrupt acknowledge wins over address decode.
    always_comb begin
        hit     = 1'b1;
        tgt_hit = TGT_RAM;
        if (iak_req)                            tgt_hit = TGT_VEC;
        else if (bus.addr_i == TPS_ADDR)        tgt_hit = TGT_TPS;
        else if (bus.addr_i == TPB_ADDR)        tgt_hit = TGT_TPB;
        else if ({1'b0, bus.addr_i} < RAM_LIMIT) tgt_hit = TGT_RAM;
        else                                    hit = 1'b0;
    end

    assign start  = iak_req || (bus.SYNC && (bus.DIN || bus.DOUT) && hit);
    assign ack    = (state_q == ST_ACK);
    assign ack_wr = ack && write_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_n;
    end

    // Acknowledge cycles carry no SYNC, so only addressed cycles abort on SYNC loss.
    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE: if (start) state_n = ST_WAIT;
            ST_WAIT: begin
                if (!bus.SYNC && (tgt_q != TGT_VEC)) state_n = ST_IDLE;
                else if (wcnt_q == WAIT_LAST)        state_n = ST_ACK;
            end
            ST_ACK:  state_n = ST_HOLD;
            ST_HOLD: if (!bus.DIN && !bus.DOUT) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_we = 2'b00;
        if (ack_wr && (tgt_q == TGT_RAM)) begin
            if (!wtbt_q)        ram_we = 2'b11;
            else if (addr_q[0]) ram_we = 2'b10;
            else                ram_we = 2'b01;
        end
    end

    assign ram_wdata = wtbt_q ? {2{bus.data_i[7:0]}} : bus.data_i;

    vm1_bus_ram #(.AW(RAM_AW)) u_ram (
        .clk   (clk),
        .addr  (addr_q[RAM_AW:1]),
        .wdata (ram_wdata),
        .we    (ram_we),
        .rdata (ram_rdata)
    );

    always_comb begin
        rd_value = ram_rdata;
        case (tgt_q)
            TGT_VEC: rd_value = VECTOR;
            TGT_TPS: rd_value = {8'h00, ready_q, ie_q, 6'b000000};
            TGT_TPB: rd_value = {8'h00, tx_data_q};
            default: rd_value = wtbt_q ? byte_lane(ram_rdata, addr_q[0]) : ram_rdata;
        endcase
    end

    // ready and tx_valid are complementary, so a drain and an accepted TPB write never share an edge.
    always_comb begin
        ready_n    = ready_q;
        ie_n       = ie_q;
        irq_n      = irq_q;
        tx_valid_n = tx_valid_q;
        tx_data_n  = tx_data_q;
        if (tx_valid_q && tx_ready) begin
            tx_valid_n = 1'b0;
            ready_n    = 1'b1;
        end
        if (ack_wr && (tgt_q == TGT_TPB) && ready_q) begin
            tx_data_n  = bus.data_i[7:0];
            tx_valid_n = 1'b1;
            ready_n    = 1'b0;
        end
        if (ack_wr && (tgt_q == TGT_TPS)) ie_n = bus.data_i[6];
        if ((ack && (tgt_q == TGT_VEC)) || (ack_wr && (tgt_q == TGT_TPS) && !bus.data_i[6]))
            irq_n = 1'b0;
        if ((!ready_q && ready_n && ie_n) || (!ie_q && ie_n && ready_n))
            irq_n = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            write_q    <= 1'b0;
            wtbt_q     <= 1'b0;
            tgt_q      <= TGT_RAM;
            wcnt_q     <= '0;
            data_q     <= '0;
            rply_q     <= 1'b0;
            ready_q    <= 1'b1;
            ie_q       <= 1'b0;
            irq_q      <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            if ((state_q == ST_IDLE) && start) begin
                addr_q  <= bus.addr_i[RAM_AW:0];
                write_q <= bus.DOUT && !iak_req;
                wtbt_q  <= bus.WTBT;
                tgt_q   <= tgt_hit;
                wcnt_q  <= '0;
            end else if ((state_q == ST_WAIT) && (wcnt_q != WAIT_LAST)) begin
                wcnt_q <= wcnt_q + 3'd1;
            end
            if (ack && !write_q) data_q <= rd_value;
            rply_q     <= (state_n == ST_HOLD);
            ready_q    <= ready_n;
            ie_q       <= ie_n;
            irq_q      <= irq_n;
            tx_valid_q <= tx_valid_n;
            tx_data_q  <= tx_data_n;
        end
    end

    assign bus.data_o = data_q;
    assign bus.RPLY   = rply_q;
    assign bus.VIRQ   = irq_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;

endmodule

// File: tb/tb_vm1_bus_responder.sv
// tb/tb_vm1_bus_responder.sv - self-checking bench for vm1_bus_responder
module tb_vm1_bus_responder;
    import vm1_bus_pkg::*;

    localparam int OP_WW = 0, OP_WB = 1, OP_RW = 2, OP_RB = 3, OP_IAK = 4;

    typedef struct {
        int          op;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp;
        logic        exp_virq;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    vm1_bus_responder_if b1 ();
    vm1_bus_responder_if b2 ();

    logic [15:0] m_addr = '0, m_data = '0;
    logic m_sync = 0, m_din = 0, m_dout = 0, m_wtbt = 0, m_iako = 0, sel = 0;
    logic [7:0] tx_data1, tx_data2;
    logic tx_valid1, tx_valid2;
    logic tx_ready1 = 1'b0, tx_ready2 = 1'b0;

    assign b1.addr_i = m_addr;
    assign b1.data_i = m_data;
    assign b1.SYNC   = sel ? 1'b0 : m_sync;
    assign b1.DIN    = sel ? 1'b0 : m_din;
    assign b1.DOUT   = sel ? 1'b0 : m_dout;
    assign b1.WTBT   = sel ? 1'b0 : m_wtbt;
    assign b1.IAKO   = sel ? 1'b0 : m_iako;
    assign b2.addr_i = m_addr;
    assign b2.data_i = m_data;
    assign b2.SYNC   = sel ? m_sync : 1'b0;
    assign b2.DIN    = sel ? m_din  : 1'b0;
    assign b2.DOUT   = sel ? m_dout : 1'b0;
    assign b2.WTBT   = sel ? m_wtbt : 1'b0;
    assign b2.IAKO   = sel ? m_iako : 1'b0;

    logic        cur_rply, cur_virq;
    logic [15:0] cur_data;
    assign cur_rply = sel ? b2.RPLY   : b1.RPLY;
    assign cur_virq = sel ? b2.VIRQ   : b1.VIRQ;
    assign cur_data = sel ? b2.data_o : b1.data_o;

    vm1_bus_responder #(.RAM_AW(14), .WAIT_STATES(0), .VECTOR(16'o000064)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(b1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1)
    );

    vm1_bus_responder #(.RAM_AW(10), .WAIT_STATES(3), .VECTOR(16'o000100)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(b2),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0o expected %0o", name, got, exp);
        end
    endtask

    // Bytes leaving the console port, sampled mid-low-phase ahead of the edge that moves them.
    logic [7:0] got_q[$];
    always @(negedge clk) begin
        #2;
        if (reset_n && tx_valid1 && tx_ready1) got_q.push_back(tx_data1);
    end

    task automatic do_cycle(input logic [15:0] a, input logic [15:0] d, input bit wr,
                            input bit bt, input bit iak, input int budget,
                            output logic [15:0] rd, output int lat);
        @(negedge clk);
        m_addr = a; m_data = d; m_wtbt = bt; m_iako = iak; m_sync = !iak;
        if (wr) m_dout = 1'b1; else m_din = 1'b1;
        lat = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (cur_rply) begin
                lat = n;
                break;
            end
        end
        rd = cur_data;
        m_din = 0; m_dout = 0; m_sync = 0; m_iako = 0; m_wtbt = 0;
        if (lat >= 0) begin
            @(negedge clk);
            check("rply_drop", {31'b0, cur_rply}, 32'd0);
        end
    endtask

    task automatic do_op(input int op, input logic [15:0] a, input logic [15:0] d,
                         input int budget, output logic [15:0] rd, output int lat);
        do_cycle(a, d, (op == OP_WW) || (op == OP_WB), (op == OP_WB) || (op == OP_RB),
                 op == OP_IAK, budget, rd, lat);
    endtask

    // Reference model for the randomized phase, console drained by a permanently ready sink.
    logic [15:0] mem_m [int];
    logic ready_m, ie_m, irq_m;
    logic [7:0] txd_m;
    logic [7:0] exp_q[$];

    function automatic logic [15:0] model_ram_read(input logic [15:0] a, input bit bt);
        logic [15:0] w;
        w = mem_m[int'(a[15:1])];
        if (!bt) return w;
        return a[0] ? (w >> 8) : (w & 16'h00FF);
    endfunction

    task automatic model_ram_write(input logic [15:0] a, input logic [15:0] d, input bit bt);
        logic [15:0] w;
        w = mem_m.exists(int'(a[15:1])) ? mem_m[int'(a[15:1])] : 16'h0000;
        if (!bt)       w = d;
        else if (a[0]) w = {d[7:0], w[7:0]};
        else           w = {w[15:8], d[7:0]};
        mem_m[int'(a[15:1])] = w;
    endtask

    task automatic model_tps_write(input logic [15:0] d);
        if (d[6] && !ie_m && ready_m) irq_m = 1'b1;
        if (!d[6]) irq_m = 1'b0;
        ie_m = d[6];
    endtask

    task automatic model_tpb_write(input logic [15:0] d);
        if (ready_m) begin
            txd_m = d[7:0];
            exp_q.push_back(d[7:0]);
            if (ie_m) irq_m = 1'b1;
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t tbl[$];
        logic [15:0] rd, a, d, exp;
        logic [15:0] pool [6];
        int lat, op;
        bit bt, is_rd, seen;

        tbl.push_back('{OP_WW, 16'o001000, 16'o123456, 16'o000000, 1'b0});
        tbl.push_back('{OP_RW, 16'o001000, 16'o000000, 16'o123456, 1'b0});
        tbl.push_back('{OP_WW, 16'o002000, 16'o000000, 16'o000000, 1'b0});
        tbl.push_back('{OP_WB, 16'o002001, 16'o000377, 16'o000000, 1'b0});
        tbl.push_back('{OP_RW, 16'o002000, 16'o000000, 16'o177400, 1'b0});
        tbl.push_back('{OP_RB, 16'o002001, 16'o000000, 16'o000377, 1'b0});
        tbl.push_back('{OP_WB, 16'o002000, 16'o000012, 16'o000000, 1'b0});
        tbl.push_back('{OP_RW, 16'o002000, 16'o000000, 16'o177412, 1'b0});
        tbl.push_back('{OP_RB, 16'o002000, 16'o000000, 16'o000012, 1'b0});
        tbl.push_back('{OP_WW, 16'o077776, 16'o055555, 16'o000000, 1'b0});
        tbl.push_back('{OP_RW, 16'o077776, 16'o000000, 16'o055555, 1'b0});
        tbl.push_back('{OP_RW, TPS_ADDR,   16'o000000, 16'o000200, 1'b0});
        tbl.push_back('{OP_RW, TPB_ADDR,   16'o000000, 16'o000000, 1'b0});
        tbl.push_back('{OP_WW, TPS_ADDR,   16'o000100, 16'o000000, 1'b1});
        tbl.push_back('{OP_RW, TPS_ADDR,   16'o000000, 16'o000300, 1'b1});
        tbl.push_back('{OP_IAK, 16'o000000, 16'o000000, 16'o000064, 1'b0});
        tbl.push_back('{OP_RW, TPS_ADDR,   16'o000000, 16'o000300, 1'b0});

        #2 reset_n = 1'b0;
        #1;
        check("reset_rply",   {31'b0, b1.RPLY},  32'd0);
        check("reset_virq",   {31'b0, b1.VIRQ},  32'd0);
        check("reset_data_o", {16'b0, b1.data_o}, 32'd0);
        check("reset_txv",    {31'b0, tx_valid1}, 32'd0);
        check("reset_txd",    {24'b0, tx_data1},  32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            do_op(tbl[i].op, tbl[i].addr, tbl[i].data, 20, rd, lat);
            check($sformatf("tbl%0d_lat", i), lat, 32'd2);
            if (tbl[i].op inside {OP_RW, OP_RB, OP_IAK})
                check($sformatf("tbl%0d_data", i), {16'b0, rd}, {16'b0, tbl[i].exp});
            check($sformatf("tbl%0d_virq", i), {31'b0, b1.VIRQ}, {31'b0, tbl[i].exp_virq});
        end

        // Console with a stalled sink, then drained.
        do_op(OP_WW, TPB_ADDR, 16'o000101, 20, rd, lat);
        check("tpb_wr_lat", lat, 32'd2);
        repeat (5) @(negedge clk);
        check("tx_valid_busy", {31'b0, tx_valid1}, 32'd1);
        check("tx_data_busy",  {24'b0, tx_data1},  32'o101);
        check("virq_busy",     {31'b0, b1.VIRQ},   32'd0);
        do_op(OP_RW, TPS_ADDR, 16'h0, 20, rd, lat);
        check("tps_busy", {16'b0, rd}, 32'o100);
        do_op(OP_WW, TPB_ADDR, 16'o000102, 20, rd, lat);
        check("tpb_busy_wr_lat", lat, 32'd2);
        do_op(OP_RW, TPB_ADDR, 16'h0, 20, rd, lat);
        check("tpb_busy_ignored", {16'b0, rd}, 32'o101);
        @(negedge clk) tx_ready1 = 1'b1;
        @(negedge clk) tx_ready1 = 1'b0;
        check("tx_valid_drained", {31'b0, tx_valid1}, 32'd0);
        check("virq_on_ready", {31'b0, b1.VIRQ}, 32'd1);
        check("tx_count1", got_q.size(), 32'd1);
        if (got_q.size() > 0) check("tx_byte1", {24'b0, got_q[0]}, 32'o101);
        do_op(OP_RW, TPS_ADDR, 16'h0, 20, rd, lat);
        check("tps_ready_again", {16'b0, rd}, 32'o300);
        do_op(OP_WB, TPB_ADDR, 16'o000016, 20, rd, lat);
        check("tx_data_0e", {24'b0, tx_data1}, 32'o016);
        @(negedge clk) tx_ready1 = 1'b1;
        @(negedge clk) tx_ready1 = 1'b0;
        check("tx_count2", got_q.size(), 32'd2);
        if (got_q.size() > 1) check("tx_byte2", {24'b0, got_q[1]}, 32'o016);
        got_q.delete();

        do_op(OP_RW, 16'o160000, 16'h0, 20, rd, lat);
        check("unmapped_160000", lat, 32'hFFFF_FFFF);
        do_op(OP_WW, 16'o100000, 16'o1, 20, rd, lat);
        check("unmapped_ram_top", lat, 32'hFFFF_FFFF);

        // Reset while the reply is held.
        @(negedge clk);
        m_addr = 16'o001000; m_sync = 1; m_din = 1;
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (b1.RPLY) begin
                seen = 1;
                break;
            end
        end
        check("hold_reached", {31'b0, seen}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("hold_reset_rply", {31'b0, b1.RPLY}, 32'd0);
        check("hold_reset_virq", {31'b0, b1.VIRQ}, 32'd0);
        m_sync = 0; m_din = 0;
        @(negedge clk) reset_n = 1'b1;
        do_op(OP_RW, TPS_ADDR, 16'h0, 20, rd, lat);
        check("tps_after_reset", {16'b0, rd}, 32'o200);

        // Reset during the wait phase drops the write.
        @(negedge clk);
        m_addr = 16'o001000; m_data = 16'o000007; m_sync = 1; m_dout = 1;
        @(negedge clk) reset_n = 1'b0;
        #1;
        check("wait_reset_rply", {31'b0, b1.RPLY}, 32'd0);
        m_sync = 0; m_dout = 0;
        @(negedge clk) reset_n = 1'b1;
        do_op(OP_RW, 16'o001000, 16'h0, 20, rd, lat);
        check("ram_kept", {16'b0, rd}, 32'o123456);

        // Randomized traffic against the reference model.
        ready_m = 1; ie_m = 0; irq_m = 0; txd_m = 8'h00;
        tx_ready1 = 1'b1;
        pool[0] = 16'o000000;
        pool[1] = 16'o077776;
        for (int i = 2; i < 6; i++) pool[i] = 16'($urandom_range(1, 16382) << 1);
        for (int i = 0; i < 6; i++) begin
            d = 16'($urandom);
            do_op(OP_WW, pool[i], d, 20, rd, lat);
            model_ram_write(pool[i], d, 0);
        end
        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 8);
            a  = pool[$urandom_range(0, 5)];
            d  = 16'($urandom);
            bt = 1'($urandom_range(0, 1));
            is_rd = 0;
            exp = '0;
            case (op)
                0: begin do_op(OP_WW, a, d, 20, rd, lat); model_ram_write(a, d, 0); end
                1: begin a[0] = bt; do_op(OP_WB, a, d, 20, rd, lat); model_ram_write(a, d, 1); end
                2: begin is_rd = 1; exp = model_ram_read(a, 0); do_op(OP_RW, a, d, 20, rd, lat); end
                3: begin a[0] = bt; is_rd = 1; exp = model_ram_read(a, 1); do_op(OP_RB, a, d, 20, rd, lat); end
                4: begin do_op(bt ? OP_WB : OP_WW, TPS_ADDR, d, 20, rd, lat); model_tps_write(d); end
                5: begin is_rd = 1; exp = {8'h00, ready_m, ie_m, 6'b0}; do_op(OP_RW, TPS_ADDR, d, 20, rd, lat); end
                6: begin do_op(bt ? OP_WB : OP_WW, TPB_ADDR, d, 20, rd, lat); model_tpb_write(d); end
                7: begin is_rd = 1; exp = {8'h00, txd_m}; do_op(OP_RW, TPB_ADDR, d, 20, rd, lat); end
                default: begin is_rd = 1; exp = 16'o000064; do_op(OP_IAK, a, d, 20, rd, lat); irq_m = 0; end
            endcase
            check($sformatf("rnd%0d_op%0d_lat", it, op), lat, 32'd2);
            if (is_rd) check($sformatf("rnd%0d_op%0d_data", it, op), {16'b0, rd}, {16'b0, exp});
            check($sformatf("rnd%0d_op%0d_virq", it, op), {31'b0, b1.VIRQ}, {31'b0, irq_m});
        end
        tx_ready1 = 1'b0;
        check("rnd_tx_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("rnd_tx_byte%0d", i), {24'b0, got_q[i]}, {24'b0, exp_q[i]});

        // Second responder: three wait states, 1K words, own vector.
        sel = 1'b1;
        do_op(OP_WW, 16'o000100, 16'o001234, 20, rd, lat);
        check("ws3_wr_lat", lat, 32'd5);
        do_op(OP_RW, 16'o000100, 16'h0, 20, rd, lat);
        check("ws3_rd_lat", lat, 32'd5);
        check("ws3_rd_data", {16'b0, rd}, 32'o001234);
        @(negedge clk);
        m_addr = 16'o000100; m_data = 16'o007777; m_sync = 1; m_dout = 1;
        repeat (2) @(negedge clk);
        m_sync = 0; m_dout = 0;
        seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (b2.RPLY) seen = 1;
        end
        check("abort_no_rply", {31'b0, seen}, 32'd0);
        do_op(OP_RW, 16'o000100, 16'h0, 20, rd, lat);
        check("abort_no_write", {16'b0, rd}, 32'o001234);
        do_op(OP_WW, 16'o003776, 16'o004321, 20, rd, lat);
        do_op(OP_RW, 16'o003776, 16'h0, 20, rd, lat);
        check("ws3_top_word", {16'b0, rd}, 32'o004321);
        do_op(OP_RW, 16'o004000, 16'h0, 20, rd, lat);
        check("ws3_above_ram", lat, 32'hFFFF_FFFF);
        do_op(OP_IAK, 16'h0, 16'h0, 20, rd, lat);
        check("ws3_iak_lat", lat, 32'd5);
        check("ws3_iak_vec", {16'b0, rd}, 32'o000100);
        check("ws3_tx_idle", {31'b0, tx_valid2}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
